// File: rtl/i2c_master_burst.sv
`default_nettype none
// =============================================================================
// Module   : i2c_master_burst
// Brief    : Burst I2C master. Runs START, 7-bit address + R/W, N data bytes
//            and STOP, with a programmable SCL quarter-period divider,
//            per-byte write/read handshakes, ACK/NACK reporting and
//            open-drain pad enables.
// Options  : I2C_CLK_STRETCH_EN - when defined, a slave holding SCL low in q2
//            stalls the divider and FSM until SCL is seen high.
// Revision : 1.0 - initial release
// =============================================================================
module i2c_master_burst #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       addr,
    input  logic             rw,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       wr_data,
    output logic             wr_ack,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             nack,
    output logic             scl_oe,
    output logic             sda_oe,
    input  logic             scl_in,
    input  logic             sda_in
);

    localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_START    = 4'd1;
    localparam logic [3:0] c_ADDR     = 4'd2;
    localparam logic [3:0] c_ADDR_ACK = 4'd3;
    localparam logic [3:0] c_WDATA    = 4'd4;
    localparam logic [3:0] c_WACK     = 4'd5;
    localparam logic [3:0] c_RDATA    = 4'd6;
    localparam logic [3:0] c_RACK     = 4'd7;
    localparam logic [3:0] c_STOP     = 4'd8;

    logic [3:0]         r_state;
    logic [3:0]         w_state_nxt;
    logic [c_DIV_W-1:0] r_div;
    logic [1:0]         r_q;        // quarter within the current bit cell
    logic [2:0]         r_bit;      // bit index within the current byte
    logic [7:0]         r_sh;
    logic [LEN_W-1:0]   r_cnt;      // bytes still to transfer
    logic               r_rw;
    logic               r_smp;      // SDA level captured at q3 entry
    logic               r_nack;
    logic               r_done;
    logic [7:0]         r_rd_data;
    logic               r_rd_valid;

    logic w_tick;
    logic w_stall;
    logic w_adv;
    logic w_sample;
    logic w_cell_end;
    logic w_scl_oe;
    logic w_sda_oe;
    logic w_wr_ack;

    assign w_tick = (r_div == c_DIV_LAST);

`ifdef I2C_CLK_STRETCH_EN
    // SCL is released in q2 of every busy state; a low pad means the slave stretches
    assign w_stall = (r_state != c_IDLE) && (r_q == 2'd2) && !scl_in;
`else
    logic w_unused;
    assign w_unused = scl_in;
    assign w_stall  = 1'b0;
`endif

    assign w_adv      = w_tick && !w_stall;
    assign w_sample   = w_adv && (r_q == 2'd2);
    assign w_cell_end = w_adv && (r_q == 2'd3);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and pad/handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_scl_oe    = 1'b0;
        w_sda_oe    = 1'b0;
        w_wr_ack    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) w_state_nxt = c_START;
            end
            c_START: begin
                w_sda_oe = r_q[1];
                if (w_cell_end) w_state_nxt = c_ADDR;
            end
            c_ADDR: begin
                w_scl_oe = !r_q[1];
                w_sda_oe = !r_sh[7];
                if (w_cell_end && (r_bit == 3'd7)) w_state_nxt = c_ADDR_ACK;
            end
            c_ADDR_ACK: begin
                w_scl_oe = !r_q[1];
                if (w_cell_end) begin
                    if (r_smp || (r_cnt == '0)) begin
                        w_state_nxt = c_STOP;
                    end else if (!r_rw) begin
                        w_state_nxt = c_WDATA;
                        w_wr_ack    = 1'b1;
                    end else begin
                        w_state_nxt = c_RDATA;
                    end
                end
            end
            c_WDATA: begin
                w_scl_oe = !r_q[1];
                w_sda_oe = !r_sh[7];
                if (w_cell_end && (r_bit == 3'd7)) w_state_nxt = c_WACK;
            end
            c_WACK: begin
                w_scl_oe = !r_q[1];
                if (w_cell_end) begin
                    if (!r_smp && (r_cnt != '0)) begin
                        w_state_nxt = c_WDATA;
                        w_wr_ack    = 1'b1;
                    end else begin
                        w_state_nxt = c_STOP;
                    end
                end
            end
            c_RDATA: begin
                w_scl_oe = !r_q[1];
                if (w_cell_end && (r_bit == 3'd7)) w_state_nxt = c_RACK;
            end
            c_RACK: begin
                w_scl_oe = !r_q[1];
                w_sda_oe = (r_cnt != '0);   // ACK while more bytes remain, NACK on the last
                if (w_cell_end) w_state_nxt = (r_cnt != '0) ? c_RDATA : c_STOP;
            end
            c_STOP: begin
                w_scl_oe = (r_q == 2'd0);
                w_sda_oe = (r_q != 2'd3);   // SDA rises while SCL is high
                if (w_cell_end) w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Divider, bit timing, shift register, byte counter and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div      <= '0;
            r_q        <= 2'd0;
            r_bit      <= 3'd0;
            r_sh       <= 8'h00;
            r_cnt      <= '0;
            r_rw       <= 1'b0;
            r_smp      <= 1'b0;
            r_nack     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            if (r_state == c_IDLE) begin
                r_div <= '0;
                r_q   <= 2'd0;
                r_bit <= 3'd0;
                if (start) begin
                    r_sh   <= {addr, rw};
                    r_rw   <= rw;
                    r_cnt  <= len;
                    r_nack <= 1'b0;
                end
            end else begin
                r_div <= (w_stall || w_tick) ? '0 : r_div + c_DIV_W'(1);
                if (w_adv) r_q <= r_q + 2'd1;
                if (w_sample) begin
                    r_smp <= sda_in;
                    if (r_state == c_RDATA) begin
                        r_sh <= {r_sh[6:0], sda_in};
                        if (r_bit == 3'd7) begin
                            r_rd_data  <= {r_sh[6:0], sda_in};
                            r_rd_valid <= 1'b1;
                        end
                    end
                end
                if (w_cell_end) begin
                    case (r_state)
                        c_ADDR, c_WDATA: begin
                            r_sh  <= {r_sh[6:0], 1'b0};
                            r_bit <= r_bit + 3'd1;
                            if ((r_state == c_WDATA) && (r_bit == 3'd7)) r_cnt <= r_cnt - LEN_W'(1);
                        end
                        c_RDATA: begin
                            r_bit <= r_bit + 3'd1;
                            if (r_bit == 3'd7) r_cnt <= r_cnt - LEN_W'(1);
                        end
                        c_ADDR_ACK, c_WACK: begin
                            if (r_smp) r_nack <= 1'b1;
                        end
                        c_STOP: begin
                            r_done <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                    if (w_wr_ack) r_sh <= wr_data;
                end
            end
        end
    end

    assign wr_ack   = w_wr_ack;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = (r_state != c_IDLE);
    assign done     = r_done;
    assign nack     = r_nack;
    assign scl_oe   = w_scl_oe;
    assign sda_oe   = w_sda_oe;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_burst.sv
`default_nettype none
// =============================================================================
// Module   : tb_i2c_master_burst
// Brief    : Directed self-checking bench for i2c_master_burst with a
//            behavioural open-drain I2C slave and bus monitor.
// Revision : 1.0 - initial release
// =============================================================================
module tb_i2c_master_burst;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] addr;
    logic       rw;
    logic [3:0] len;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       done;
    logic       nack;
    logic       scl_oe;
    logic       sda_oe;

    logic s_hold = 1'b0;   // slave clock stretch
    logic s_drv  = 1'b0;   // slave pulls SDA low
    wire  scl_bus = ~(scl_oe | s_hold);
    wire  sda_bus = ~(sda_oe | s_drv);

    i2c_master_burst #(.CLK_DIV(4), .LEN_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw), .len(len),
        .wr_data(wr_data), .wr_ack(wr_ack), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .nack(nack), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .scl_in(scl_bus), .sda_in(sda_bus)
    );

    always #5 clk = ~clk;

    // Slave configuration (written by the test sequence only)
    logic       s_present = 1'b1;
    logic       s_wack    = 1'b1;
    logic [7:0] rd_vec [0:7];
    logic [7:0] wr_vec [0:15];

    // Slave / monitor state (written by the slave process only)
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic       s_active = 1'b0, s_rd = 1'b0;
    logic [7:0] s_sh = 8'h00;
    int         bit_n = 9, byte_n = 0, mon_n = 0, stop_n = 0;
    logic [7:0] mon     [0:63];
    logic       mon_ack [0:63];

    // Behavioural slave: decodes START/STOP, records every byte and its ACK bit,
    // drives ACKs and read data after SCL falls
    always @(negedge clk) begin
        if (scl_bus && prev_scl && prev_sda && !sda_bus) begin
            bit_n = 0; byte_n = 0; s_active = 1'b1; s_drv = 1'b0;
        end else if (scl_bus && prev_scl && !prev_sda && sda_bus) begin
            stop_n++; s_active = 1'b0; s_drv = 1'b0;
        end else if (!prev_scl && scl_bus && s_active) begin
            if (bit_n < 8) begin
                s_sh = {s_sh[6:0], sda_bus};
                bit_n++;
                if (bit_n == 8) begin
                    if (mon_n < 64) mon[mon_n] = s_sh;
                    if (byte_n == 0) s_rd = s_sh[0];
                end
            end else begin
                if (mon_n < 64) mon_ack[mon_n] = sda_bus;
                mon_n++;
                bit_n = 9;
                if (sda_bus && (byte_n == 0 || s_rd)) s_active = 1'b0;
            end
        end else if (prev_scl && !scl_bus && s_active) begin
            if (bit_n == 9) begin bit_n = 0; byte_n++; end
            if (bit_n == 8)                     s_drv = (byte_n == 0) ? s_present : (!s_rd && s_wack);
            else if (s_rd && byte_n > 0)        s_drv = ~rd_vec[byte_n-1][7-bit_n];
            else                                s_drv = 1'b0;
        end
        prev_scl = scl_bus;
        prev_sda = sda_bus;
    end

    int         n_cmp = 0, n_bad = 0;
    int         n_wrack, n_rdv, n_done, period, n_cyc;
    logic       timed_out, busy_at_done, busy_after_start;
    logic [7:0] rd_got [0:7];

    // Issue one transaction and collect handshake activity until done
    task automatic run_txn(input logic [6:0] a, input logic r, input logic [3:0] n,
                           input int poke, input logic stretch);
        int      wr_idx, last_fall, hcnt;
        logic    upd, ps, held;
        longint  t0;
        n_wrack = 0; n_rdv = 0; n_done = 0; period = 0; n_cyc = 0;
        timed_out = 1'b1; busy_at_done = 1'b1;
        wr_idx = 0; upd = 1'b0; last_fall = -1; hcnt = 0; held = 1'b0;
        wr_data = wr_vec[0];
        @(negedge clk);
        addr = a; rw = r; len = n; start = 1'b1; t0 = $time;
        @(negedge clk);
        start = 1'b0;
        busy_after_start = busy;
        ps = scl_oe;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (upd) begin wr_data = wr_vec[wr_idx]; upd = 1'b0; end
            if (wr_ack) begin n_wrack++; wr_idx++; upd = 1'b1; end
            if (rd_valid) begin if (n_rdv < 8) rd_got[n_rdv] = rd_data; n_rdv++; end
            if (scl_oe && !ps) begin
                if (last_fall >= 0 && period == 0) period = c - last_fall;
                last_fall = c;
            end
            ps = scl_oe;
            if (c == poke) begin start = 1'b1; addr = 7'h7F; end else start = 1'b0;
            if (stretch) begin
                if (!held && bit_n == 3 && byte_n == 0 && scl_oe) begin
                    s_hold = 1'b1; held = 1'b1;
                end else if (s_hold && !scl_oe) begin
                    // dropped inside the 41st cycle, so 40 cycle-ends see SCL low
                    hcnt++;
                    if (hcnt == 41) s_hold = 1'b0;
                end
            end
            if (done) begin
                n_done++; busy_at_done = busy; timed_out = 1'b0;
                n_cyc = int'(($time - t0) / 10);
                break;
            end
        end
        start = 1'b0; s_hold = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) n_done++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; addr = 7'h00; rw = 1'b0; len = 4'd0; wr_data = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++; if ({scl_oe, sda_oe} !== 2'b00) begin n_bad++; $display("FAIL reset_oe: got %b want 00", {scl_oe, sda_oe}); end
        n_cmp++; if ({busy, done, nack} !== 3'b000) begin n_bad++; $display("FAIL reset_status: got %b want 000", {busy, done, nack}); end
        n_cmp++; if ({wr_ack, rd_valid, rd_data} !== 10'h000) begin n_bad++; $display("FAIL reset_data: got %h want 000", {wr_ack, rd_valid, rd_data}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write;
        int base, stops;
        base = mon_n; stops = stop_n; s_present = 1'b1; s_wack = 1'b1;
        wr_vec[0] = 8'hA5; wr_vec[1] = 8'h3C;
        run_txn(7'h2A, 1'b0, 4'd2, -1, 1'b0);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL write_timeout: got %b want 0", timed_out); end
        n_cmp++; if (busy_after_start !== 1'b1) begin n_bad++; $display("FAIL write_busy: got %b want 1", busy_after_start); end
        n_cmp++; if ({mon[base], mon[base+1], mon[base+2]} !== 24'h54A53C) begin n_bad++; $display("FAIL write_bytes: got %h want 54a53c", {mon[base], mon[base+1], mon[base+2]}); end
        n_cmp++; if ({mon_ack[base], mon_ack[base+1], mon_ack[base+2]} !== 3'b000) begin n_bad++; $display("FAIL write_acks: got %b want 000", {mon_ack[base], mon_ack[base+1], mon_ack[base+2]}); end
        n_cmp++; if (n_wrack !== 2) begin n_bad++; $display("FAIL write_wr_ack: got %0d want 2", n_wrack); end
        n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL write_done: got %0d want 1", n_done); end
        n_cmp++; if (busy_at_done !== 1'b0) begin n_bad++; $display("FAIL write_busy_at_done: got %b want 0", busy_at_done); end
        n_cmp++; if (nack !== 1'b0) begin n_bad++; $display("FAIL write_nack: got %b want 0", nack); end
        n_cmp++; if (period !== 16) begin n_bad++; $display("FAIL write_scl_period: got %0d want 16", period); end
        n_cmp++; if (stop_n - stops !== 1) begin n_bad++; $display("FAIL write_stop: got %0d want 1", stop_n - stops); end
    endtask

    task automatic test_nack;
        int base, stops;
        base = mon_n; stops = stop_n; s_present = 1'b0;
        wr_vec[0] = 8'h77; wr_vec[1] = 8'h88;
        run_txn(7'h11, 1'b0, 4'd2, -1, 1'b0);
        s_present = 1'b1;
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL nack_timeout: got %b want 0", timed_out); end
        n_cmp++; if (mon_n - base !== 1) begin n_bad++; $display("FAIL nack_byte_count: got %0d want 1", mon_n - base); end
        n_cmp++; if ({mon[base], mon_ack[base]} !== 9'h045) begin n_bad++; $display("FAIL nack_addr: got %h want 045", {mon[base], mon_ack[base]}); end
        n_cmp++; if (nack !== 1'b1) begin n_bad++; $display("FAIL nack_flag: got %b want 1", nack); end
        n_cmp++; if (n_wrack !== 0) begin n_bad++; $display("FAIL nack_wr_ack: got %0d want 0", n_wrack); end
        n_cmp++; if ({n_done, stop_n - stops} !== {32'd1, 32'd1}) begin n_bad++; $display("FAIL nack_done_stop: got %0d/%0d want 1/1", n_done, stop_n - stops); end
    endtask

    task automatic test_read;
        int base;
        base = mon_n;
        rd_vec[0] = 8'hCC; rd_vec[1] = 8'h01; rd_vec[2] = 8'hFF;
        run_txn(7'h2A, 1'b1, 4'd3, -1, 1'b0);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL read_timeout: got %b want 0", timed_out); end
        n_cmp++; if (n_rdv !== 3) begin n_bad++; $display("FAIL read_rd_valid: got %0d want 3", n_rdv); end
        n_cmp++; if ({rd_got[0], rd_got[1], rd_got[2]} !== 24'hCC01FF) begin n_bad++; $display("FAIL read_rd_data: got %h want cc01ff", {rd_got[0], rd_got[1], rd_got[2]}); end
        n_cmp++; if ({mon[base], mon[base+1], mon[base+2], mon[base+3]} !== 32'h55CC01FF) begin n_bad++; $display("FAIL read_bus_bytes: got %h want 55cc01ff", {mon[base], mon[base+1], mon[base+2], mon[base+3]}); end
        n_cmp++; if ({mon_ack[base], mon_ack[base+1], mon_ack[base+2], mon_ack[base+3]} !== 4'b0001) begin n_bad++; $display("FAIL read_acks: got %b want 0001", {mon_ack[base], mon_ack[base+1], mon_ack[base+2], mon_ack[base+3]}); end
        n_cmp++; if ({nack, n_done} !== {1'b0, 32'd1}) begin n_bad++; $display("FAIL read_nack_done: got %b/%0d want 0/1", nack, n_done); end
    endtask

    task automatic test_probe;
        int base, stops;
        base = mon_n; stops = stop_n;
        run_txn(7'h2A, 1'b0, 4'd0, -1, 1'b0);
        n_cmp++; if ({mon_n - base, stop_n - stops} !== {32'd1, 32'd1}) begin n_bad++; $display("FAIL probe_bytes_stop: got %0d/%0d want 1/1", mon_n - base, stop_n - stops); end
        n_cmp++; if ({mon[base], mon_ack[base]} !== 9'h0A8) begin n_bad++; $display("FAIL probe_addr: got %h want 0a8", {mon[base], mon_ack[base]}); end
        n_cmp++; if ({n_wrack, n_rdv, n_done} !== {32'd0, 32'd0, 32'd1}) begin n_bad++; $display("FAIL probe_handshakes: got %0d/%0d/%0d want 0/0/1", n_wrack, n_rdv, n_done); end
        // 11 bit cells of 16 clk from the accepting edge, seen one negedge later
        n_cmp++; if (n_cyc !== 177) begin n_bad++; $display("FAIL probe_length: got %0d want 177", n_cyc); end
    endtask

    task automatic test_reset_mid;
        int   base;
        logic hit;
        hit = 1'b0;
        @(negedge clk);
        addr = 7'h2A; rw = 1'b0; len = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (busy && byte_n == 0 && bit_n == 4 && scl_oe) begin hit = 1'b1; break; end
        end
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL rstmid_reach_bit5: got %b want 1", hit); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({scl_oe, sda_oe, busy, done} !== 4'b0000) begin n_bad++; $display("FAIL rstmid_release: got %b want 0000", {scl_oe, sda_oe, busy, done}); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        base = mon_n;
        wr_vec[0] = 8'h96; wr_vec[1] = 8'h0F;
        run_txn(7'h2A, 1'b0, 4'd2, -1, 1'b0);
        n_cmp++; if ({mon[base], mon[base+1], mon[base+2]} !== 24'h54960F) begin n_bad++; $display("FAIL rstmid_after: got %h want 54960f", {mon[base], mon[base+1], mon[base+2]}); end
    endtask

    task automatic test_back_to_back;
        int base;
        base = mon_n;
        wr_vec[0] = 8'h5A; wr_vec[1] = 8'hC3;
        run_txn(7'h2A, 1'b0, 4'd2, 100, 1'b0);
        n_cmp++; if ({mon[base], mon[base+1], mon[base+2]} !== 24'h545AC3) begin n_bad++; $display("FAIL b2b_ignore_start: got %h want 545ac3", {mon[base], mon[base+1], mon[base+2]}); end
        n_cmp++; if ({n_done, busy} !== {32'd1, 1'b0}) begin n_bad++; $display("FAIL b2b_done_idle: got %0d/%b want 1/0", n_done, busy); end
        base = mon_n;
        run_txn(7'h2A, 1'b0, 4'd0, -1, 1'b0);
        n_cmp++; if ({mon_n - base, mon[base]} !== {32'd1, 8'h54}) begin n_bad++; $display("FAIL b2b_second: got %0d/%h want 1/54", mon_n - base, mon[base]); end
    endtask

`ifdef I2C_CLK_STRETCH_EN
    task automatic test_stretch;
        int base;
        base = mon_n;
        run_txn(7'h2A, 1'b0, 4'd0, -1, 1'b1);
        n_cmp++; if ({mon[base], mon_ack[base]} !== 9'h0A8) begin n_bad++; $display("FAIL stretch_addr: got %h want 0a8", {mon[base], mon_ack[base]}); end
        n_cmp++; if (n_cyc !== 217) begin n_bad++; $display("FAIL stretch_length: got %0d want 217", n_cyc); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_nack();
        test_read();
        test_probe();
        test_reset_mid();
        test_back_to_back();
`ifdef I2C_CLK_STRETCH_EN
        test_stretch();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_master_burst.md
Name: i2c_master_burst

Overview:
Parametrised I2C master that runs complete multi-byte transactions: START, 7-bit address plus R/W, N data bytes, and STOP. It adds a programmable SCL divider, per-byte write and read handshakes, ACK/NACK reporting and open-drain pad outputs. It sits between the chip control logic and the uio pads, and replaces the single-byte fixed-divider master.

Parameters:
CLK_DIV, 4, clk cycles per SCL quarter-period (>=2); SCL period = 4*CLK_DIV clk cycles
LEN_W, 4, width of byte-count field; max burst = 2^LEN_W-1 bytes

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
start  in  1  request a transaction; sampled only in IDLE
addr  in  7  target address; latched on accepted start
rw  in  1  0=write, 1=read; latched on accepted start
len  in  LEN_W  number of data bytes; latched on accepted start
wr_data  in  8  next write byte; captured on the cycle wr_ack=1
wr_ack  out  1  1-cycle pulse when wr_data is loaded into the shift register
rd_data  out  8  last received byte
rd_valid  out  1  1-cycle pulse when rd_data updates
busy  out  1  transaction in progress
done  out  1  1-cycle pulse at end of transaction
nack  out  1  sticky: address or write byte not acknowledged; cleared on next accepted start
scl_oe  out  1  1 = pull SCL low; 0 = release
sda_oe  out  1  1 = pull SDA low; 0 = release
scl_in  in  1  SCL pad level
sda_in  in  1  SDA pad level

Behaviour:
- Reset: scl_oe=0, sda_oe=0, busy=0, done=0, nack=0, wr_ack=0, rd_valid=0, rd_data=0, state=IDLE, divider=0.
- Quarter tick: the divider counts 0..CLK_DIV-1 and emits `tick` at CLK_DIV-1. All bus actions advance only on `tick`.
- Bit cell (4 quarters):
  - q0 and q1: SCL low. SDA updates at q0 entry.
  - q2 and q3: SCL released.
  - sda_in is sampled at q3 entry.
- States: IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, STOP.
- IDLE:
  - start=1 latches addr, rw and len, clears nack, and sets busy=1 the next cycle.
  - The divider restarts at 0 when the transaction begins.
  - start while busy is ignored.
- START: SDA released for 2 quarters, then SDA low for 2 quarters, with SCL released throughout. Then ADDR.
- ADDR: shift {addr,rw}, MSB first, over 8 bit cells. Then ADDR_ACK.
- ADDR_ACK: release SDA for one cell and sample.
  - sda_in=1: nack=1, go to STOP.
  - len=0: go to STOP (address probe).
  - Otherwise go to WDATA if rw=0, else RDATA.
- WDATA: on entry, pulse wr_ack and load wr_data. Shift 8 bits, then WACK.
- WACK: release SDA and sample.
  - NACK: nack=1, go to STOP.
  - Otherwise, if bytes remaining > 0, go to WDATA; else go to STOP.
- RDATA: SDA released; shift in 8 bits, MSB first. On the 8th sample, update rd_data and pulse rd_valid. Then RACK.
- RACK: master drives sda_oe=1 (ACK) if more bytes remain, else sda_oe=0 (NACK). Then RDATA or STOP.
- STOP: drive SDA low with SCL low, release SCL, then release SDA after 2 quarters. Then IDLE.
- End of transaction: done pulses on the cycle of IDLE entry; busy=0 in that same cycle.
- Byte counter: LEN_W bits, decremented per completed byte. No wrap: the transaction ends at 0.
- wr_data timing: wr_data must be stable on the wr_ack cycle. The next byte is needed no earlier than 9 SCL periods later.
- Reset mid-transaction: both oe signals go to 0 the next cycle (bus released, no STOP), state IDLE, all outputs return to reset values.
- start and rst in the same cycle: rst wins.

Optional Feature:
I2C_CLK_STRETCH_EN:
- When defined: in q2, if scl_in=0 after SCL is released, the divider and FSM hold until scl_in=1. The q3 sample timing is then measured from the release.
- When undefined: scl_in is unused and the timing is purely divider-driven.

Test Plan:
- CLK_DIV=4, write addr=0x2A, len=2, bytes 0xA5,0x3C, slave ACKs all -> SDA shows 0x54, 0xA5, 0x3C; wr_ack pulses twice; done=1 once; nack=0; SCL period 16 clk.
- Write to addr=0x11 with no slave (SDA pulled high) -> nack=1 after the 9th SCL; STOP issued; no wr_ack; done pulse.
- Read addr=0x2A, len=3, slave returns 0xCC,0x01,0xFF -> three rd_valid pulses with matching rd_data; master ACK, ACK, then NACK on the 9th bit of each byte.
- len=0 probe with ACK -> START, 0x54, ACK, STOP; no wr_ack or rd_valid; done pulse.
- With I2C_CLK_STRETCH_EN, slave holds SCL low for 40 clk after bit 3 of the address byte -> FSM stalls 40 clk; byte is still correct.
- rst=1 during the 5th write bit -> scl_oe=sda_oe=0 the next cycle; busy=0; subsequent start runs a normal transaction.
